sprite_anim_rom: RTL and testbench

Parametrised, animated sprite store for the maze renderer. It holds several multi-frame square sprites (Pac-Man mouth cycle, ghost skirt cycle) and advances the animation frame from the per-video-frame tick. It serves single-pixel lookups with orientation applied in hardware (right, left, up, down), so one bitmap set covers all four movement directions. It sits between the sprite-position logic and the colour mapper, with one registered read per request.

---
 rtl/sprite_anim_rom.sv | 130 +++++++++++++
 tb/tb_sprite_anim_rom.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_rom.sv
// rtl/sprite_anim_rom.sv - animated square sprite store with hardware orientation
//
// Purpose: holds NUM_SPRITES x NUM_FRAMES bitmaps of W x W pixels, steps the
// animation frame every FRAME_DIV enabled frame ticks, and returns one pixel per
// read with the requested orientation applied. Read latency is one cycle.
//
// Ports:
//   Clk          system clock
//   Reset_n      asynchronous active-low reset
//   frame_tick   one-cycle pulse per video frame
//   anim_en      allow frame_tick to advance the animation
//   rd_en        pixel read request, accepted every cycle it is high
//   sprite_id    sprite select (ids >= NUM_SPRITES read as transparent)
//   dir          orientation: 0 right, 1 left, 2 up, 3 down
//   row, col     output-space pixel coordinates
//   pixel        registered pixel value, 1 = opaque
//   pixel_valid  pixel answers the read accepted on the previous edge
//   frame_idx    current animation frame
module sprite_anim_rom #(
   parameter int W           = 8,
   parameter int NUM_SPRITES = 2,
   parameter int NUM_FRAMES  = 2,
   parameter int FRAME_DIV   = 8,
   parameter logic [0:NUM_SPRITES*NUM_FRAMES*W-1][W-1:0] ROM_INIT = {
      8'h18, 8'h3C, 8'h7E, 8'h7C, 8'h78, 8'h7C, 8'h3E, 8'h1C,
      8'h18, 8'h3C, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h3E, 8'h1C,
      8'h18, 8'h3C, 8'h4A, 8'hC9, 8'hFF, 8'hE7, 8'hC3, 8'h81,
      8'h18, 8'h3C, 8'h4A, 8'hC9, 8'hFF, 8'hFF, 8'hDB, 8'h99}
) (
   input  logic                                                  Clk,
   input  logic                                                  Reset_n,
   input  logic                                                  frame_tick,
   input  logic                                                  anim_en,
   input  logic                                                  rd_en,
   input  logic [((NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1)-1:0] sprite_id,
   input  logic [1:0]                                            dir,
   input  logic [$clog2(W)-1:0]                                  row,
   input  logic [$clog2(W)-1:0]                                  col,
   output logic                                                  pixel,
   output logic                                                  pixel_valid,
   output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0]   frame_idx
);

   localparam int CW    = $clog2(W);
   localparam int FW    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
   localparam int DW    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int DEPTH = NUM_SPRITES * NUM_FRAMES * W;
   localparam int AW    = $clog2(DEPTH);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [FW-1:0] frame_idx_q, frame_idx_d;
   logic          pixel_q, pixel_d;
   logic          pixel_valid_q, pixel_valid_d;

   logic [CW-1:0] sr, sc, bit_sel;
   logic [AW-1:0] addr;
   logic [W-1:0]  rom_word;
   logic          in_range;
   int            word_idx;

   // Animation divider: one frame step per FRAME_DIV enabled ticks.
   always_comb begin
      div_cnt_d   = div_cnt_q;
      frame_idx_d = frame_idx_q;
      if (frame_tick && anim_en) begin
         if (div_cnt_q == DW'(FRAME_DIV - 1)) begin
            div_cnt_d = '0;
            if (NUM_FRAMES == 1 || frame_idx_q == FW'(NUM_FRAMES - 1)) begin
               frame_idx_d = '0;
            end else begin
               frame_idx_d = frame_idx_q + 1'b1;
            end
         end else begin
            div_cnt_d = div_cnt_q + 1'b1;
         end
      end
   end

   // Orientation: W is a power of two, so W-1-x is just the bitwise inverse.
   always_comb begin
      sr = row;
      sc = col;
      unique case (dir)
         2'd0: begin sr = row;  sc = col;  end
         2'd1: begin sr = row;  sc = ~col; end
         2'd2: begin sr = col;  sc = ~row; end
         2'd3: begin sr = ~col; sc = row;  end
         default: begin sr = row; sc = col; end
      endcase
   end

   // Reads use the registered frame, so a step on the same edge is not seen
   // until the following read.
   always_comb begin
      in_range = int'(sprite_id) < NUM_SPRITES;
      word_idx = (int'(sprite_id) * NUM_FRAMES + int'(frame_idx_q)) * W + int'(sr);
      addr     = AW'(word_idx);
      rom_word = in_range ? ROM_INIT[addr] : '0;
      bit_sel  = ~sc;
   end

   // Output stage: valid only follows rd_en; pixel holds when no read is made.
   always_comb begin
      pixel_d       = pixel_q;
      pixel_valid_d = 1'b0;
      if (rd_en) begin
         pixel_valid_d = 1'b1;
         pixel_d       = in_range & rom_word[bit_sel];
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         div_cnt_q     <= '0;
         frame_idx_q   <= '0;
         pixel_q       <= 1'b0;
         pixel_valid_q <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         frame_idx_q   <= frame_idx_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
      end
   end

   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;
   assign frame_idx   = frame_idx_q;

endmodule

// File: tb/tb_sprite_anim_rom.sv
// tb/tb_sprite_anim_rom.sv - directed self-checking bench for sprite_anim_rom
module tb_sprite_anim_rom;

   localparam logic [0:47][7:0] ROM3 = {
      8'h18, 8'h3C, 8'h7E, 8'h7C, 8'h78, 8'h7C, 8'h3E, 8'h1C,
      8'h18, 8'h3C, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h3E, 8'h1C,
      8'h18, 8'h3C, 8'h4A, 8'hC9, 8'hFF, 8'hE7, 8'hC3, 8'h81,
      8'h18, 8'h3C, 8'h4A, 8'hC9, 8'hFF, 8'hFF, 8'hDB, 8'h99,
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
      8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   logic       Clk = 1'b0;
   logic       Reset_n;
   logic       frame_tick, anim_en, rd_en;
   logic [0:0] sprite_id;
   logic [1:0] sprite_id3;
   logic [1:0] dir;
   logic [2:0] row, col;
   logic       pixel, pixel_valid;
   logic [0:0] frame_idx;
   logic       pixel3, pixel_valid3;
   logic [0:0] frame_idx3;

   int n_vec = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   sprite_anim_rom u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .anim_en(anim_en),
      .rd_en(rd_en), .sprite_id(sprite_id), .dir(dir), .row(row), .col(col),
      .pixel(pixel), .pixel_valid(pixel_valid), .frame_idx(frame_idx));

   sprite_anim_rom #(.W(8), .NUM_SPRITES(3), .NUM_FRAMES(2), .FRAME_DIV(8), .ROM_INIT(ROM3)) u_dut3 (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .anim_en(anim_en),
      .rd_en(rd_en), .sprite_id(sprite_id3), .dir(dir), .row(row), .col(col),
      .pixel(pixel3), .pixel_valid(pixel_valid3), .frame_idx(frame_idx3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic ticks(input int n);
      rd_en = 1'b0;
      for (int i = 0; i < n; i++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         cyc();
      end
   endtask

   // sprite, dir, row, col, expected pixel (sprite 0 / 1, frame 0)
   typedef struct { logic [0:0] s; logic [1:0] d; logic [2:0] r; logic [2:0] c; logic e; } vec_t;
   vec_t vecs [9];

   initial begin
      vecs[0] = '{1'b0, 2'd0, 3'd3, 3'd5, 1'b1};
      vecs[1] = '{1'b0, 2'd0, 3'd3, 3'd6, 1'b0};
      vecs[2] = '{1'b0, 2'd1, 3'd3, 3'd2, 1'b1};
      vecs[3] = '{1'b0, 2'd1, 3'd3, 3'd1, 1'b0};
      vecs[4] = '{1'b0, 2'd2, 3'd0, 3'd3, 1'b0};
      vecs[5] = '{1'b0, 2'd2, 3'd3, 3'd0, 1'b1};
      vecs[6] = '{1'b0, 2'd3, 3'd7, 3'd3, 1'b0};
      vecs[7] = '{1'b0, 2'd3, 3'd1, 3'd3, 1'b1};
      vecs[8] = '{1'b1, 2'd0, 3'd2, 3'd1, 1'b1};

      Reset_n = 1'b1; frame_tick = 1'b0; anim_en = 1'b0; rd_en = 1'b0;
      sprite_id = '0; sprite_id3 = '0; dir = '0; row = '0; col = '0;

      // Asynchronous reset between edges
      #2 Reset_n = 1'b0;
      #1;
      check("rst_pixel", 32'(pixel), 32'd0);
      check("rst_valid", 32'(pixel_valid), 32'd0);
      check("rst_frame", 32'(frame_idx), 32'd0);
      check("rst_valid3", 32'(pixel_valid3), 32'd0);
      cyc(); cyc();
      Reset_n = 1'b1;
      cyc();

      // Orientation, back-to-back reads, one-cycle latency
      for (int i = 0; i < 9; i++) begin
         rd_en = 1'b1; sprite_id = vecs[i].s; dir = vecs[i].d; row = vecs[i].r; col = vecs[i].c;
         cyc();
         check($sformatf("orient%0d_pixel", i), 32'(pixel), 32'(vecs[i].e));
         check($sformatf("orient%0d_valid", i), 32'(pixel_valid), 32'd1);
      end
      rd_en = 1'b0;
      cyc();
      check("idle_valid", 32'(pixel_valid), 32'd0);
      check("idle_hold", 32'(pixel), 32'd1);

      // Out-of-range sprite on the 3-sprite build
      rd_en = 1'b1; sprite_id3 = 2'd2; dir = 2'd0; row = 3'd3; col = 3'd5;
      cyc();
      check("spr2_pixel", 32'(pixel3), 32'd1);
      sprite_id3 = 2'd3;
      cyc();
      check("oor_pixel", 32'(pixel3), 32'd0);
      check("oor_valid", 32'(pixel_valid3), 32'd1);
      rd_en = 1'b0;

      // Animation divider
      anim_en = 1'b1;
      ticks(7);
      check("tick7_frame", 32'(frame_idx), 32'd0);
      rd_en = 1'b1; sprite_id = 1'b0; dir = 2'd0; row = 3'd3; col = 3'd6; frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      check("tick8_frame", 32'(frame_idx), 32'd1);
      check("same_edge_pixel", 32'(pixel), 32'd0);
      cyc();
      check("next_edge_pixel", 32'(pixel), 32'd1);
      check("next_edge_valid", 32'(pixel_valid), 32'd1);
      rd_en = 1'b0;

      anim_en = 1'b0;
      ticks(20);
      check("anim_off_frame", 32'(frame_idx), 32'd1);
      anim_en = 1'b1;
      ticks(7);
      check("tick15_frame", 32'(frame_idx), 32'd1);
      ticks(1);
      check("tick16_frame", 32'(frame_idx), 32'd0);
      check("tick16_frame3", 32'(frame_idx3), 32'd0);

      // Mid-stream reset
      ticks(8);
      check("pre_rst_frame", 32'(frame_idx), 32'd1);
      rd_en = 1'b1; sprite_id = 1'b0; dir = 2'd0; row = 3'd3; col = 3'd6;
      cyc();
      check("pre_rst_pixel", 32'(pixel), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(pixel_valid), 32'd0);
      check("mid_rst_frame", 32'(frame_idx), 32'd0);
      check("mid_rst_pixel", 32'(pixel), 32'd0);
      cyc(); cyc();
      check("hold_rst_valid", 32'(pixel_valid), 32'd0);
      Reset_n = 1'b1;
      cyc();
      check("post_rst_pixel", 32'(pixel), 32'd0);
      check("post_rst_valid", 32'(pixel_valid), 32'd1);
      check("post_rst_frame", 32'(frame_idx), 32'd0);
      col = 3'd5;
      cyc();
      check("post_rst_pixel2", 32'(pixel), 32'd1);
      rd_en = 1'b0;
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
